// File: rtl/tse_phy_link_mgr.sv
// Clause-22 MDIO master and link sequencer driving the TSE MAC speed selects.
// Define TSE_PHY_MGMT_HOST_EN to add the host register-access port.
//
// state     | meaning
// WAIT_RST  | settle delay after reset
// INIT_WR   | BMCR write (AN enable + restart)
// IDLE      | poll interval, host grant point
// RD_BMSR   | read BMSR, keep link bit
// RD_SPD    | read PHY-specific status
// UPDATE    | load link/speed outputs
// HOST_XFER | host-requested frame
module tse_phy_link_mgr #(
    parameter logic [4:0]  PHY_ADDR    = 5'd0,
    parameter int          MDC_DIV     = 25,
    parameter int          RESET_WAIT  = 500000,
    parameter int          POLL_CYCLES = 5000000,
    parameter logic [15:0] INIT_DATA   = 16'h1200,
    parameter logic [4:0]  SPEED_REG   = 5'd17
) (
    input  logic        clk_clk,
    input  logic        reset_reset,
    output logic        mdc,
    input  logic        mdio_in,
    output logic        mdio_out,
    output logic        mdio_oen,
    output logic        set_1000,
    output logic        set_10,
    output logic        link_up,
    output logic [1:0]  speed,
    output logic        busy
`ifdef TSE_PHY_MGMT_HOST_EN
    ,
    input  logic        host_req,
    input  logic        host_wr,
    input  logic [4:0]  host_reg,
    input  logic [15:0] host_wdata,
    output logic        host_ack,
    output logic [15:0] host_rdata
`endif
);

    localparam int CMAX = (POLL_CYCLES > RESET_WAIT) ? POLL_CYCLES : RESET_WAIT;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int DW   = (MDC_DIV > 1) ? $clog2(MDC_DIV) : 1;

    typedef enum logic [2:0] {
        WAIT_RST, INIT_WR, IDLE, RD_BMSR, RD_SPD, UPDATE, HOST_XFER
    } state_t;

    state_t         state;
    logic [CW-1:0]  cnt;
    logic [DW-1:0]  div_cnt;
    logic [5:0]     bit_idx;
    logic [63:0]    tx_sh;
    logic [63:0]    l_vec;
    logic [15:0]    rx_sh;
    logic [15:0]    l_data;
    logic [4:0]     l_reg;
    logic           l_read;
    logic           launch;
    logic           frm_read;
    logic           frm_end;
    logic           bmsr_link;
    logic           host_pend;
    logic [1:0]     spd_code;
    logic           spd_link;

`ifdef TSE_PHY_MGMT_HOST_EN
    assign host_pend = host_req & ~host_ack;
`else
    assign host_pend = 1'b0;
`endif

    assign frm_end  = busy & mdc & (div_cnt == '0) & (bit_idx == 6'd63);
    assign spd_code = rx_sh[15:14];
    assign spd_link = bmsr_link & rx_sh[10];
    // Read frames keep driving ones; the pad is released from TA onward anyway.
    assign l_vec = {32'hFFFF_FFFF, 2'b01, (l_read ? 2'b10 : 2'b01), PHY_ADDR, l_reg,
                    (l_read ? 2'b11 : 2'b10), (l_read ? 16'hFFFF : l_data)};

    always_comb begin
        launch = 1'b0;
        l_read = 1'b1;
        l_reg  = 5'd1;
        l_data = 16'hFFFF;
        case (state)
            WAIT_RST: if (cnt == '0) begin
                launch = 1'b1;
                l_read = 1'b0;
                l_reg  = 5'd0;
                l_data = INIT_DATA;
            end
            IDLE: if (!host_pend && cnt == '0) launch = 1'b1;
            RD_SPD: if (!busy) begin
                launch = 1'b1;
                l_reg  = SPEED_REG;
            end
`ifdef TSE_PHY_MGMT_HOST_EN
            HOST_XFER: if (!busy) begin
                launch = 1'b1;
                l_read = ~host_wr;
                l_reg  = host_reg;
                l_data = host_wdata;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge clk_clk) begin
        if (reset_reset) begin
            state     <= WAIT_RST;
            cnt       <= CW'(RESET_WAIT - 1);
            mdc       <= 1'b0;
            mdio_out  <= 1'b1;
            mdio_oen  <= 1'b1;
            busy      <= 1'b0;
            div_cnt   <= '0;
            bit_idx   <= '0;
            tx_sh     <= '1;
            rx_sh     <= '0;
            frm_read  <= 1'b0;
            bmsr_link <= 1'b0;
            set_1000  <= 1'b0;
            set_10    <= 1'b0;
            link_up   <= 1'b0;
            speed     <= 2'b01;
`ifdef TSE_PHY_MGMT_HOST_EN
            host_ack   <= 1'b0;
            host_rdata <= '0;
`endif
        end else begin
`ifdef TSE_PHY_MGMT_HOST_EN
            host_ack <= 1'b0;
`endif
            if (launch) begin
                busy     <= 1'b1;
                mdc      <= 1'b0;
                div_cnt  <= DW'(MDC_DIV - 1);
                bit_idx  <= '0;
                tx_sh    <= {l_vec[62:0], 1'b1};
                mdio_out <= l_vec[63];
                mdio_oen <= 1'b0;
                frm_read <= l_read;
            end else if (busy) begin
                if (div_cnt != '0) begin
                    div_cnt <= div_cnt - 1'b1;
                end else begin
                    div_cnt <= DW'(MDC_DIV - 1);
                    if (!mdc) begin
                        mdc <= 1'b1;
                        if (bit_idx >= 6'd48) rx_sh <= {rx_sh[14:0], mdio_in};
                    end else begin
                        mdc <= 1'b0;
                        if (bit_idx == 6'd63) begin
                            busy     <= 1'b0;
                            mdio_out <= 1'b1;
                            mdio_oen <= 1'b1;
                        end else begin
                            bit_idx  <= bit_idx + 6'd1;
                            mdio_out <= tx_sh[63];
                            tx_sh    <= {tx_sh[62:0], 1'b1};
                            mdio_oen <= frm_read & (bit_idx >= 6'd45);
                        end
                    end
                end
            end

            case (state)
                WAIT_RST: begin
                    if (cnt == '0) state <= INIT_WR;
                    else           cnt   <= cnt - 1'b1;
                end
                INIT_WR: if (frm_end) begin
                    state <= IDLE;
                    cnt   <= CW'(POLL_CYCLES - 1);
                end
                IDLE: begin
                    if (host_pend)      state <= HOST_XFER;
                    else if (cnt == '0) state <= RD_BMSR;
                    else                cnt   <= cnt - 1'b1;
                end
                RD_BMSR: if (frm_end) begin
                    bmsr_link <= rx_sh[2];
                    state     <= RD_SPD;
                end
                RD_SPD: if (frm_end) state <= UPDATE;
                UPDATE: begin
                    // Code 11 covers both the reserved code and an all-ones absent PHY.
                    if (spd_code == 2'b11) begin
                        link_up  <= 1'b0;
                        set_1000 <= 1'b0;
                        set_10   <= 1'b0;
                    end else begin
                        speed    <= spd_code;
                        link_up  <= spd_link;
                        set_1000 <= spd_link & (spd_code == 2'b10);
                        set_10   <= spd_link & (spd_code == 2'b00);
                    end
                    cnt   <= CW'(POLL_CYCLES - 1);
                    state <= host_pend ? HOST_XFER : IDLE;
                end
                HOST_XFER: if (frm_end) begin
`ifdef TSE_PHY_MGMT_HOST_EN
                    host_ack   <= 1'b1;
                    host_rdata <= rx_sh;
`endif
                    state <= IDLE;
                end
                default: state <= WAIT_RST;
            endcase
        end
    end

endmodule

// File: tb/tb_tse_phy_link_mgr.sv
// Directed bench for tse_phy_link_mgr with a small MDIO PHY model.
// Host-port scenario is compiled only with TSE_PHY_MGMT_HOST_EN.
module tb_tse_phy_link_mgr;

    localparam int DIV = 2;
    localparam int RW  = 10;
    localparam int PC  = 20;
    localparam logic [63:0] INIT_FRAME = {32'hFFFF_FFFF, 16'b0101_0000_0000_0010, 16'h1200};
    localparam logic [45:0] BMSR_HDR   = {32'hFFFF_FFFF, 14'b0110_00000_00001};
    localparam logic [45:0] SPD_HDR    = {32'hFFFF_FFFF, 14'b0110_00000_10001};
    localparam logic [63:0] READ_OEN   = {46'b0, 18'h3FFFF};

    logic clk_clk = 1'b0;
    logic reset_reset = 1'b1;
    logic mdc, mdio_in, mdio_out, mdio_oen, set_1000, set_10, link_up, busy;
    logic [1:0] speed;

    int checks = 0;
    int errors = 0;

    // PHY model state
    logic [15:0] bmsr_val = 16'h796D;
    logic [15:0] spd_val  = 16'hAC00;
    logic [15:0] rd_word;
    logic        absent = 1'b0;
    int          bit_cnt = 0;
    logic        mdc_q = 1'b0;
    logic [63:0] cap = '0;
    logic [63:0] oen_cap = '0;
    logic [4:0]  reg_sel = '0;

`ifdef TSE_PHY_MGMT_HOST_EN
    logic        host_req = 1'b0;
    logic        host_wr = 1'b0;
    logic [4:0]  host_reg = '0;
    logic [15:0] host_wdata = '0;
    logic        host_ack;
    logic [15:0] host_rdata;
    int          ack_cnt = 0;
    always @(posedge clk_clk) if (host_ack === 1'b1) ack_cnt++;
`endif

    always #5 clk_clk = ~clk_clk;

    tse_phy_link_mgr #(
        .PHY_ADDR(5'd0), .MDC_DIV(DIV), .RESET_WAIT(RW), .POLL_CYCLES(PC),
        .INIT_DATA(16'h1200), .SPEED_REG(5'd17)
    ) dut (
        .clk_clk(clk_clk), .reset_reset(reset_reset), .mdc(mdc), .mdio_in(mdio_in),
        .mdio_out(mdio_out), .mdio_oen(mdio_oen), .set_1000(set_1000), .set_10(set_10),
        .link_up(link_up), .speed(speed), .busy(busy)
`ifdef TSE_PHY_MGMT_HOST_EN
        , .host_req(host_req), .host_wr(host_wr), .host_reg(host_reg),
        .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata)
`endif
    );

    // PHY model: capture the frame on MDC rising, answer reads from the register map
    always @(negedge clk_clk) begin
        mdc_q <= mdc;
        if (busy === 1'b0) begin
            bit_cnt <= 0;
        end else if (mdc === 1'b1 && mdc_q === 1'b0) begin
            bit_cnt <= bit_cnt + 1;
            cap     <= {cap[62:0], mdio_out};
            oen_cap <= {oen_cap[62:0], mdio_oen};
            if (bit_cnt == 45) reg_sel <= {cap[3:0], mdio_out};
        end
    end

    always_comb begin
        rd_word = (reg_sel == 5'd1) ? bmsr_val : spd_val;
        mdio_in = 1'b1;
        if (!absent && bit_cnt >= 48 && bit_cnt <= 63) mdio_in = rd_word[4'(63 - bit_cnt)];
    end

    task automatic wait_any_frame(output logic [4:0] r, output bit ok);
        logic prev;
        prev = busy;
        ok = 1'b0;
        r = '0;
        for (int i = 0; i < 3000 && !ok; i++) begin
            @(negedge clk_clk);
            if (prev === 1'b1 && busy === 1'b0) begin
                ok = 1'b1;
                r = reg_sel;
            end
            prev = busy;
        end
    endtask

    task automatic wait_frame(input logic [4:0] want, input string tag);
        logic [4:0] r;
        bit ok;
        bit hit;
        hit = 1'b0;
        for (int k = 0; k < 4 && !hit; k++) begin
            wait_any_frame(r, ok);
            if (!ok) break;
            if (r == want) hit = 1'b1;
        end
        checks++;
        if (!hit) begin
            errors++;
            $display("FAIL %s: frame for reg %0d not observed within bound", tag, want);
        end
    endtask

    task automatic test_init_frame(input string tag);
        int n;
        int len;
        bit seen;
        n = 0;
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge clk_clk); #1;
            n++;
            if (busy === 1'b1) seen = 1'b1;
        end
        checks++;
        if (!seen || n != RW) begin
            errors++;
            $display("FAIL %s_start: busy rose after %0d cycles (seen=%0b), want %0d", tag, n, seen, RW);
        end
        len = 1;
        for (int i = 0; i < 1000; i++) begin
            @(posedge clk_clk); #1;
            if (busy !== 1'b1) break;
            len++;
        end
        checks++;
        if (len != 128 * DIV) begin
            errors++;
            $display("FAIL %s_len: busy high %0d cycles, want %0d", tag, len, 128 * DIV);
        end
        checks++;
        if (cap !== INIT_FRAME) begin
            errors++;
            $display("FAIL %s_frame: got %h want %h", tag, cap, INIT_FRAME);
        end
        checks++;
        if (oen_cap !== 64'h0) begin
            errors++;
            $display("FAIL %s_oen: got %h want %h", tag, oen_cap, 64'h0);
        end
        checks++;
        if ({mdio_oen, mdio_out, mdc} !== 3'b110) begin
            errors++;
            $display("FAIL %s_idle_pins: oen/out/mdc got %b want 110", tag, {mdio_oen, mdio_out, mdc});
        end
    endtask

    task automatic test_reset();
        reset_reset = 1'b1;
        repeat (3) @(posedge clk_clk);
        @(negedge clk_clk);
        checks++;
        if ({mdc, mdio_out, mdio_oen, set_1000, set_10, link_up, speed, busy} !== 9'b0_1_1_0_0_0_01_0) begin
            errors++;
            $display("FAIL reset_vals: got %b want %b",
                     {mdc, mdio_out, mdio_oen, set_1000, set_10, link_up, speed, busy}, 9'b011000010);
        end
        reset_reset = 1'b0;
        test_init_frame("init");
    endtask

    task automatic test_gigabit();
        bmsr_val = 16'h796D;
        spd_val  = 16'hAC00;
        wait_frame(5'd1, "gig_bmsr_wait");
        checks++;
        if (cap[63:18] !== BMSR_HDR || oen_cap !== READ_OEN) begin
            errors++;
            $display("FAIL bmsr_frame: hdr %h oen %h want hdr %h oen %h", cap[63:18], oen_cap, BMSR_HDR, READ_OEN);
        end
        wait_frame(5'd17, "gig_spd_wait");
        checks++;
        if (cap[63:18] !== SPD_HDR) begin
            errors++;
            $display("FAIL spd_frame: hdr %h want %h", cap[63:18], SPD_HDR);
        end
        checks++;
        if (link_up !== 1'b0) begin
            errors++;
            $display("FAIL gig_latency: link_up %b at frame end, want 0", link_up);
        end
        @(negedge clk_clk);
        checks++;
        if ({link_up, speed, set_1000, set_10} !== 5'b1_10_1_0) begin
            errors++;
            $display("FAIL gig_out: link/speed/s1000/s10 got %b want 11010", {link_up, speed, set_1000, set_10});
        end
    endtask

    task automatic test_10m_and_loss();
        spd_val = 16'h0400;
        wait_frame(5'd17, "10m_wait");
        @(negedge clk_clk);
        checks++;
        if ({link_up, speed, set_1000, set_10} !== 5'b1_00_0_1) begin
            errors++;
            $display("FAIL 10m_out: got %b want 10001", {link_up, speed, set_1000, set_10});
        end
        bmsr_val = 16'h7969;
        wait_frame(5'd17, "loss_wait");
        @(negedge clk_clk);
        checks++;
        if ({link_up, speed, set_1000, set_10} !== 5'b0_00_0_0) begin
            errors++;
            $display("FAIL loss_out: got %b want 00000", {link_up, speed, set_1000, set_10});
        end
    endtask

    task automatic test_absent();
        absent = 1'b1;
        bmsr_val = 16'h796D;
        for (int p = 0; p < 3; p++) begin
            wait_frame(5'd17, "absent_wait");
            @(negedge clk_clk);
            checks++;
            if ({link_up, speed, set_1000, set_10} !== 5'b0_00_0_0) begin
                errors++;
                $display("FAIL absent_out poll %0d: got %b want 00000", p, {link_up, speed, set_1000, set_10});
            end
        end
        absent = 1'b0;
    endtask

    task automatic test_reserved();
        spd_val = 16'h4400;
        wait_frame(5'd17, "100m_wait");
        @(negedge clk_clk);
        checks++;
        if ({link_up, speed, set_1000, set_10} !== 5'b1_01_0_0) begin
            errors++;
            $display("FAIL 100m_out: got %b want 10100", {link_up, speed, set_1000, set_10});
        end
        spd_val = 16'hC400;
        wait_frame(5'd17, "rsvd_wait");
        @(negedge clk_clk);
        checks++;
        if ({link_up, speed, set_1000, set_10} !== 5'b0_01_0_0) begin
            errors++;
            $display("FAIL rsvd_out: got %b want 00100", {link_up, speed, set_1000, set_10});
        end
    endtask

    task automatic test_reset_mid_frame();
        bit hit;
        spd_val = 16'hAC00;
        wait_frame(5'd17, "mid_setup");
        wait_frame(5'd1, "mid_bmsr");
        hit = 1'b0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            @(negedge clk_clk);
            if (busy === 1'b1 && bit_cnt == 40) hit = 1'b1;
        end
        checks++;
        if (!hit || link_up !== 1'b1 || mdio_oen !== 1'b0) begin
            errors++;
            $display("FAIL mid_setup_state: hit %b link %b oen %b want 1 1 0", hit, link_up, mdio_oen);
        end
        reset_reset = 1'b1;
        @(negedge clk_clk);
        checks++;
        if ({mdc, mdio_out, mdio_oen, set_1000, set_10, link_up, speed, busy} !== 9'b0_1_1_0_0_0_01_0) begin
            errors++;
            $display("FAIL mid_reset_vals: got %b want %b",
                     {mdc, mdio_out, mdio_oen, set_1000, set_10, link_up, speed, busy}, 9'b011000010);
        end
        reset_reset = 1'b0;
        test_init_frame("reinit");
    endtask

`ifdef TSE_PHY_MGMT_HOST_EN
    task automatic test_host_arbitration();
        logic [4:0] r;
        bit ok;
        bit hit;
        wait_frame(5'd17, "host_setup");
        hit = 1'b0;
        for (int i = 0; i < 1000 && !hit; i++) begin
            @(negedge clk_clk);
            if (busy === 1'b1 && bit_cnt == 10) hit = 1'b1;
        end
        host_wr = 1'b1;
        host_reg = 5'd4;
        host_wdata = 16'h01E1;
        host_req = 1'b1;
        ack_cnt = 0;
        wait_any_frame(r, ok);
        wait_any_frame(r, ok);
        checks++;
        if (!ok || r !== 5'd17) begin
            errors++;
            $display("FAIL host_order: frame after BMSR was reg %0d, want 17", r);
        end
        wait_any_frame(r, ok);
        checks++;
        if (!ok || cap !== {32'hFFFF_FFFF, 4'b0101, 5'd0, 5'd4, 2'b10, 16'h01E1}) begin
            errors++;
            $display("FAIL host_frame: got %h want %h", cap, {32'hFFFF_FFFF, 4'b0101, 5'd0, 5'd4, 2'b10, 16'h01E1});
        end
        host_req = 1'b0;
        repeat (40) @(negedge clk_clk);
        checks++;
        if (ack_cnt != 1) begin
            errors++;
            $display("FAIL host_ack_count: got %0d want 1", ack_cnt);
        end
    endtask
`endif

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1);
    end

    initial begin
        test_reset();
        test_gigabit();
        test_10m_and_loss();
        test_absent();
        test_reserved();
        test_reset_mid_frame();
`ifdef TSE_PHY_MGMT_HOST_EN
        test_host_arbitration();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tse_phy_link_mgr.md
# tse_phy_link_mgr

- Standalone Clause-22 MDIO master and link sequencer for the RGMII PHY attached to the triple-speed Ethernet MAC.
- After reset it programs the PHY for auto-negotiation, then periodically polls PHY status.
- It drives the MAC speed-select inputs (`set_1000`, `set_10`) from the negotiated speed and link state.
- It owns the PHY MDIO pins; the MAC's internal MDIO master is left unconnected.

## Interface

Parameters:
- `PHY_ADDR`, 5'd0: PHY MDIO address.
- `MDC_DIV`, 25: `clk_clk` cycles per MDC half-period (MDC = 50 MHz / 50 = 1 MHz).
- `RESET_WAIT`, 500000: cycles idle after reset before the first frame.
- `POLL_CYCLES`, 5000000: cycles from the end of one poll pair to the start of the next.
- `INIT_DATA`, 16'h1200: BMCR value written at init (AN enable + AN restart).
- `SPEED_REG`, 5'd17: PHY-specific status register; bits [15:14] = speed, bit 10 = real-time link.

Ports:
- `clk_clk` in 1: system clock; single clock domain.
- `reset_reset` in 1: synchronous, active-high reset.
- `mdc` out 1: MDIO clock.
- `mdio_in` in 1: MDIO pad input.
- `mdio_out` out 1: MDIO pad output.
- `mdio_oen` out 1: pad output enable, active low (0 = drive).
- `set_1000` out 1: to MAC `set_1000`.
- `set_10` out 1: to MAC `set_10`.
- `link_up` out 1: PHY reports link.
- `speed` out 2: last decoded speed; 00 = 10M, 01 = 100M, 10 = 1000M.
- `busy` out 1: an MDIO frame is in progress.

## Operation

States: `WAIT_RST` → `INIT_WR` → `IDLE` → `RD_BMSR` → `RD_SPD` → `UPDATE` → `IDLE`.

- **WAIT_RST:** counts `RESET_WAIT` cycles.
- **INIT_WR:** one write frame, register 0, data `INIT_DATA`.
- **IDLE:** counts `POLL_CYCLES`.
- **RD_BMSR:** reads register 1; BMSR bit 2 is captured.
- **RD_SPD:** reads `SPEED_REG`.
- **UPDATE:** one cycle; loads the outputs.

Frame format, 64 bits, MSB first:
- 32 ones (preamble), ST `01`, OP, `PHY_ADDR`, REGAD, TA, 16 data bits.
- Write: OP `01`, TA `10`.
- Read: OP `10`. `mdio_oen` = 1 for the 2 TA bits and the 16 data bits.

Update rule:
- `link_up` = BMSR[2] & SPD[10].
- `speed` = SPD[15:14].
- `set_1000` = `link_up` & (speed == 10).
- `set_10` = `link_up` & (speed == 00).
- Otherwise both are 0 (100M).

Boundary conditions:
- SPD read returns 16'hFFFF (no PHY): `link_up` = 0, `speed` holds, `set_*` = 0.
- Speed code 11 (reserved): treated as link down.
- `mdio_oen` = 1 and `mdio_out` = 1 whenever no frame is active.

## Timing

Reset values:
- `mdc` 0, `mdio_out` 1, `mdio_oen` 1.
- `set_1000` 0, `set_10` 0, `link_up` 0.
- `speed` 01, `busy` 0.
- State `WAIT_RST`.

MDC and bit timing:
- One bit = 2×`MDC_DIV` cycles. `mdc` low for the first half, high for the second.
- Output bits change on the cycle `mdc` falls.
- Read bits are sampled from `mdio_in` on the cycle `mdc` rises.
- Frame = 128×`MDC_DIV` cycles.

`busy`:
- Rises the cycle a frame starts.
- Falls the cycle after its last MDC high phase ends.

Update latency:
- Outputs update 1 cycle after the `RD_SPD` frame ends.
- Outputs are otherwise stable: no glitching between polls.

`reset_reset` asserted mid-frame:
- Aborts immediately.
- All outputs take reset values on the next edge.
- The sequence restarts from `WAIT_RST`.

## Configuration

`TSE_PHY_MGMT_HOST_EN`: adds a host register-access port.
- Ports:
  - `host_req` in 1, `host_wr` in 1, `host_reg` in 5, `host_wdata` in 16.
  - `host_ack` out 1, `host_rdata` out 16.
- Handshake:
  - `host_req` is held high until `host_ack`.
  - `host_ack` is a 1-cycle pulse after the frame ends; `host_rdata` is valid in that cycle.
- Arbitration:
  - A pending host request is granted at the next frame boundary, ahead of any poll frame.
  - A poll pair is never split; a host frame waits until after `RD_SPD`.
  - `INIT_WR` always goes first.
- Without the macro: the ports are absent and the poller owns MDIO exclusively.

## Test plan

- **Reset/init:** `MDC_DIV`=2, `RESET_WAIT`=10.
  - Frame starts at cycle 10; first 32 bits are 1.
  - Header = `0101_00000_00000_10`, data 16'h1200.
  - Frame is 256 cycles; `busy` high throughout.
- **Gigabit link:** PHY model returns BMSR 16'h796D, SPD 16'hAC00.
  - `link_up` = 1, `speed` = 10, `set_1000` = 1, `set_10` = 0, one cycle after the frame ends.
- **10M then link loss:**
  - SPD 16'h0400 → `set_10` = 1.
  - Next poll, BMSR 16'h7969 → `link_up` = 0, `set_10` = 0, `set_1000` = 0.
- **Absent PHY:** `mdio_in` held 1 (reads 16'hFFFF) → `link_up` = 0 and both `set_*` = 0 persist across 3 polls.
- **Reset mid-frame:** assert `reset_reset` at bit 40 of `RD_SPD`.
  - Next cycle: `mdio_oen` = 1, `mdc` = 0, outputs at reset values.
  - Init frame reissued after `RESET_WAIT`.
- **Host arbitration (macro on):** `host_req` write, reg 4, data 16'h01E1, raised during `RD_BMSR`.
  - Host frame issued only after `RD_SPD` completes.
  - `host_ack` pulses once.
